// File: rtl/mpsoc_msi_ahb3_sram_slave.sv
// AHB-Lite SRAM slave: wait-state insertion, byte-lane writes, registered reads with write forwarding.
// Define MPSOC_MSI_AHB3_SRAM_ERR_EN to enable address/size decode errors (two-cycle ERROR response).
module mpsoc_msi_ahb3_sram_slave #(
  parameter int PLEN        = 64,
  parameter int XLEN        = 64,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic            HRESP
);

  localparam int NB = XLEN / 8;
  localparam int BL = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`ifdef MPSOC_MSI_AHB3_SRAM_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            dp_q, dp_d;
  logic            wr_q;
  logic [IW-1:0]   idx_q;
  logic [NB-1:0]   be_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic            acc;
  logic            err_a;
  logic            ld_rd;
  logic            commit;
  logic [IW-1:0]   idx_a;
  logic [IW-1:0]   rd_idx;
  logic [BL-1:0]   off_a;
  logic [2:0]      size_eff;
  logic            unused_ok;

  // Lanes covered by a transfer; the offset is aligned down to the size first.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [BL-1:0] off);
    logic [NB-1:0] m;
    int n;
    int base;
    n    = 1 << size;
    base = int'(off) & ~(n - 1);
    for (int b = 0; b < NB; b++) m[b] = (b >= base) && (b < base + n);
    return m;
  endfunction

  assign acc      = HSEL & HREADY & HTRANS[1];
  assign idx_a    = HADDR[BL +: IW];
  assign off_a    = HADDR[BL-1:0];
  assign size_eff = (HSIZE > 3'(BL)) ? 3'(BL) : HSIZE;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR};

`ifdef MPSOC_MSI_AHB3_SRAM_ERR_EN
  assign err_a = ((HADDR >> (BL + IW)) != '0) | (HSIZE > 3'(BL)) |
                 (|(off_a & BL'((32'd1 << HSIZE) - 32'd1)));
`else
  assign err_a = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dp_d      = dp_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    ld_rd     = 1'b0;
    rd_idx    = idx_a;
    unique case (state_q)
      IDLE, ERR2: begin
        if (state_q == ERR2) HRESP = ERR_ON;
        state_d = IDLE;
        dp_d    = 1'b0;
        if (acc) begin
          if (err_a) begin
            state_d = ERR1;
          end else begin
            dp_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = WAIT;
              cnt_d   = WS_LOAD;
            end else begin
              ld_rd = ~HWRITE;
            end
          end
        end
      end
      WAIT: begin
        HREADYOUT = 1'b0;
        rd_idx    = idx_q;
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          ld_rd   = ~wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = ERR_ON;
        state_d   = ERR2;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write commits in the IDLE cycle that completes its data phase.
  assign commit = (state_q == IDLE) & dp_q & wr_q;

  always_comb begin
    rdata_d = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int b = 0; b < NB; b++)
        if (be_q[b]) rdata_d[b*8 +: 8] = HWDATA[b*8 +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dp_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      if (ld_rd) rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (((state_q == IDLE) || (state_q == ERR2)) && acc) begin
      idx_q <= idx_a;
      wr_q  <= HWRITE;
      be_q  <= lane_mask(size_eff, off_a);
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < NB; b++)
        if (be_q[b]) mem[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
    end
  end

  assign HRDATA = rdata_q;

endmodule

// File: doc/mpsoc_msi_ahb3_sram_slave.md
# mpsoc_msi_ahb3_sram_slave

AHB-Lite slave that terminates one slave port of the MSI interconnect and backs it with an on-chip word-addressed memory array. It decodes the address phase, inserts a programmable number of wait states, commits byte-lane-masked writes, and returns registered read data with write forwarding. It produces OKAY or two-cycle ERROR responses. One instance connects directly to each `slv_*` bundle of the interconnect.

## Interface
- `PLEN`, 64, address width
- `XLEN`, 64, data width; must be 32 or 64
- `MEM_DEPTH`, 256, memory size in XLEN-bit words; must be a power of two
- `WAIT_STATES`, 0, wait cycles inserted per OKAY transfer; range 0..15
- `HCLK` input 1 — clock, all state changes on the rising edge
- `HRESETn` input 1 — asynchronous active-low reset
- `HSEL` input 1 — slave select
- `HADDR` input PLEN — byte address
- `HWDATA` input XLEN — write data, valid in the data phase
- `HRDATA` output XLEN — read data
- `HWRITE` input 1 — 1 = write
- `HSIZE` input 3 — transfer size (log2 bytes)
- `HBURST` input 3 — burst type; ignored, each beat is decoded independently
- `HPROT` input 4 — ignored
- `HTRANS` input 2 — IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- `HMASTLOCK` input 1 — ignored
- `HREADY` input 1 — bus-level ready, from the interconnect `slv_HREADYOUT`
- `HREADYOUT` output 1 — slave ready
- `HRESP` output 1 — 0 = OKAY, 1 = ERROR

## Operation
- **Address-phase accept:** `acc = HSEL & HREADY & HTRANS[1]`. On an `acc` edge, capture the address, HWRITE and HSIZE.
- **Decode:** `BL = log2(XLEN/8)`. Word index = `HADDR[BL +: log2(MEM_DEPTH)]`.
- **Error conditions:** any of
  - any nonzero HADDR bit above the index field;
  - `HSIZE > BL`;
  - HADDR not aligned to HSIZE.
- **Byte-lane mask:** `((1<<(1<<HSIZE))-1) << HADDR[BL-1:0]`.
- **FSM states:** IDLE, WAIT, ERR1, ERR2.
  - IDLE: HREADYOUT=1, HRESP=0. On `acc`:
    - error condition → ERR1;
    - else if WAIT_STATES>0 → WAIT, loading the counter with WAIT_STATES-1;
    - else stay in IDLE; the next cycle is the data phase.
  - WAIT: HREADYOUT=0, HRESP=0. The counter decrements each cycle; at 0 → IDLE, and that IDLE cycle completes the data phase.
  - ERR1: HREADYOUT=0, HRESP=1. Unconditionally → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Returns to IDLE, accepting a new `acc` exactly as IDLE does.
- **Writes:** committed on the edge ending the data phase (HREADYOUT=1, OKAY). Only masked bytes of `HWDATA` are written. Errored writes never modify memory.
- **Reads:** HRDATA is registered and loaded on the edge entering the data-phase completion cycle.
  - If a write commits on that same edge to the same word, the committing bytes are forwarded into HRDATA.
  - HRDATA holds its value otherwise.
- **IDLE/BUSY transfers and HSEL=0:** zero-wait OKAY, no state change, no memory access.
- **Reset:** HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, counter=0, no pending write. Memory contents are not reset.
- **Reset mid-transfer:** the transfer is abandoned and a pending write is dropped.

## Timing
- **Latency:** OKAY transfers take WAIT_STATES+1 data-phase cycles. An ERROR takes exactly 2 cycles.
- **Back-to-back:** NONSEQ/SEQ every cycle at WAIT_STATES=0 runs with no bubbles.
- **Read-after-write:** a read following a write to the same address returns the new data with no added stall.
- **Address pipelining:** the next address phase overlaps the current data phase. It is sampled only when HREADY=1. During wait states HREADY=0, so no new transfer is accepted.
- **Aborts:** an address phase presented in ERR2 (HREADY=1) is accepted normally. The protocol allows the master to cancel by driving IDLE in ERR2.

## Configuration
- **`MPSOC_MSI_AHB3_SRAM_ERR_EN` defined:** error decoding and the ERR1/ERR2 response are as above.
- **Undefined:**
  - HRESP is tied to 0 and ERR1/ERR2 are unreachable.
  - Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH words.
  - Oversize HSIZE is treated as a full-word transfer.
  - Misaligned addresses are aligned down to HSIZE.

## Test plan
- **Reset mid-WAIT:** WAIT_STATES=2, assert HRESETn low during WAIT → HREADYOUT=1, HRESP=0, HRDATA=0 asynchronously; the pending write to 0x10 is absent on a later readback.
- **Zero-wait write/read:** XLEN=64, WAIT_STATES=0. Write 0xDEADBEEF_CAFEF00D to 0x08 (HSIZE=3), then read 0x08 in the next address phase → HRDATA=0xDEADBEEF_CAFEF00D one cycle later, HREADYOUT never low.
- **Byte write with forwarding:** byte write 0xAA to 0x0B, immediately followed by a word read of 0x08 → HRDATA=0xDEADBEEF_CAFEF00D with byte 3 replaced, i.e. 0xDEADBEEF_AAFEF00D.
- **Wait states:** WAIT_STATES=3, NONSEQ read → HREADYOUT low for exactly 3 cycles, then high with correct data and HRESP=0.
- **Out-of-range with ERR_EN:** write to 0x1_0000 with MEM_DEPTH=256, ERR_EN defined →
  - cycle 1: HREADYOUT=0, HRESP=1;
  - cycle 2: HREADYOUT=1, HRESP=1;
  - address 0x0 is unchanged.
- **Out-of-range without ERR_EN:** same write → HRESP stays 0 and the write lands at word 0 (wrap).
